matmul_apb_slave: RTL



---
 rtl/matmul_pkg.sv | 38 +++
 rtl/matmul_operand_buf.sv | 33 +++
 rtl/matmul_apb_slave.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/matmul_pkg.sv
// Shared constants for the matmul APB slave: widths, register map, control-field layout
// and the APB transfer FSM state type.
package matmul_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int BUS_WIDTH  = 32;
    localparam int MAX_DIM    = BUS_WIDTH / DATA_WIDTH;
    localparam int ADDR_WIDTH = 16;
    localparam int LINE_W     = $clog2(MAX_DIM);
    localparam int CTRL_WIDTH = 16;

    localparam logic [4:0] REG_CONTROL   = 5'h00;
    localparam logic [4:0] REG_OPERAND_A = 5'h04;
    localparam logic [4:0] REG_OPERAND_B = 5'h08;
    localparam logic [4:0] REG_FLAGS     = 5'h0C;
    localparam logic [4:0] REG_SP        = 5'h10;

    localparam int CTRL_START  = 0;
    localparam int CTRL_MODE   = 1;
    localparam int CTRL_WR_TGT = 2;
    localparam int CTRL_RD_TGT = 4;
    localparam int CTRL_N      = 8;
    localparam int CTRL_K      = 10;
    localparam int CTRL_M      = 12;

    // Bits that physically exist in the control register; everything else reads back as 0.
    localparam logic [CTRL_WIDTH-1:0] CTRL_MASK = CTRL_WIDTH'(
        (1 << CTRL_START) | (1 << CTRL_MODE) | (3 << CTRL_WR_TGT) | (3 << CTRL_RD_TGT) |
        (3 << CTRL_N) | (3 << CTRL_K) | (3 << CTRL_M));

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_ACCESS   = 2'd2,
        ST_ACC_WAIT = 2'd3
    } apb_state_e;

endpackage

// File: rtl/matmul_operand_buf.sv
// Operand line buffer: MAX_DIM lines of BUS_WIDTH bits, written one element lane at a time.
module matmul_operand_buf
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         we_i,
    input  logic [LINE_W-1:0]            line_i,
    input  logic [MAX_DIM-1:0]           strb_i,
    input  logic [BUS_WIDTH-1:0]         wdata_i,
    output logic [BUS_WIDTH-1:0]         rdata_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] lines_o
);

    logic [BUS_WIDTH-1:0] mem_q [MAX_DIM];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int l = 0; l < MAX_DIM; l++) mem_q[l] <= '0;
        end else if (we_i) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (strb_i[e]) mem_q[line_i][e*DATA_WIDTH +: DATA_WIDTH] <= wdata_i[e*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign rdata_o = mem_q[line_i];

    for (genvar l = 0; l < MAX_DIM; l++) begin : g_flat
        assign lines_o[l*BUS_WIDTH +: BUS_WIDTH] = mem_q[l];
    end

endmodule

// File: rtl/matmul_apb_slave.sv
// APB3 slave front end of the matmul accelerator: register decode, operand buffers, core start/busy.
// Define MATMUL_PSTRB_EN to let pstrb_i mask element writes; otherwise every write is full-word.
module matmul_apb_slave
    import matmul_pkg::*;
(
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         psel_i,
    input  logic                         penable_i,
    input  logic                         pwrite_i,
    input  logic [ADDR_WIDTH-1:0]        paddr_i,
    input  logic [MAX_DIM-1:0]           pstrb_i,
    input  logic [BUS_WIDTH-1:0]         pwdata_i,
    output logic [BUS_WIDTH-1:0]         prdata_o,
    output logic                         pready_o,
    output logic                         pslverr_o,
    output logic                         busy_o,
    output logic                         start_o,
    output logic [CTRL_WIDTH-1:0]        ctrl_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opa_o,
    output logic [MAX_DIM*BUS_WIDTH-1:0] opb_o,
    input  logic                         done_i,
    input  logic [BUS_WIDTH-1:0]         flags_i,
    input  logic                         flags_we_i,
    output logic                         sp_rd_en_o,
    output logic [LINE_W+1:0]            sp_rd_addr_o,
    input  logic [BUS_WIDTH-1:0]         sp_rd_data_i
);

    apb_state_e            state_q, state_d;
    logic [4:0]            region;
    logic [LINE_W-1:0]     line;
    logic [MAX_DIM-1:0]    wr_strb;
    logic                  is_ctrl, is_opa, is_opb, is_flags, is_sp, rw_reg;
    logic                  access_err, sp_read, commit, start_fire;
    logic                  busy_q, start_q;
    logic [CTRL_WIDTH-1:0] ctrl_q;
    logic [BUS_WIDTH-1:0]  flags_q, opa_rdata, opb_rdata, reg_rdata;
    logic                  unused_inputs;

    assign region = paddr_i[4:0];
    assign line   = paddr_i[5 +: LINE_W];

`ifdef MATMUL_PSTRB_EN
    assign wr_strb       = pstrb_i;
    assign unused_inputs = ^paddr_i[ADDR_WIDTH-1:5+LINE_W];
`else
    assign wr_strb       = '1;
    assign unused_inputs = ^{paddr_i[ADDR_WIDTH-1:5+LINE_W], pstrb_i};
`endif

    assign is_ctrl  = (region == REG_CONTROL);
    assign is_opa   = (region == REG_OPERAND_A);
    assign is_opb   = (region == REG_OPERAND_B);
    assign is_flags = (region == REG_FLAGS);
    assign is_sp    = (region == REG_SP);
    assign rw_reg   = is_ctrl | is_opa | is_opb;

    // Reads of any mapped region are always legal; writes need a writable region and an idle core.
    assign access_err = ~(rw_reg | is_flags | is_sp) | (pwrite_i & (~rw_reg | busy_q));
    assign sp_read    = is_sp & ~pwrite_i;
    assign start_fire = commit & is_ctrl & pwdata_i[CTRL_START] & wr_strb[CTRL_START / DATA_WIDTH];

    always_comb begin
        reg_rdata = '0;
        if (is_ctrl)       reg_rdata = BUS_WIDTH'(ctrl_q);
        else if (is_opa)   reg_rdata = opa_rdata;
        else if (is_opb)   reg_rdata = opb_rdata;
        else if (is_flags) reg_rdata = flags_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // state_d is the phase of the current bus cycle, so pready can rise in the first ACCESS cycle.
    always_comb begin
        state_d      = ST_IDLE;
        pready_o     = 1'b0;
        pslverr_o    = 1'b0;
        prdata_o     = '0;
        sp_rd_en_o   = 1'b0;
        sp_rd_addr_o = '0;
        commit       = 1'b0;
        if (psel_i) begin
            if (!penable_i) begin
                state_d = ST_SETUP;
            end else if (state_q == ST_SETUP) begin
                state_d = ST_ACCESS;
                if (sp_read) begin
                    sp_rd_en_o   = 1'b1;
                    sp_rd_addr_o = {ctrl_q[CTRL_RD_TGT +: 2], line};
                end else begin
                    pready_o  = 1'b1;
                    pslverr_o = access_err;
                    prdata_o  = access_err ? '0 : reg_rdata;
                    commit    = pwrite_i & ~access_err;
                end
            end else if (state_q == ST_ACCESS && sp_read) begin
                state_d  = ST_ACC_WAIT;
                pready_o = 1'b1;
                prdata_o = sp_rd_data_i;
            end
        end
    end

    // A start commit raises busy and the start pulse together; the stored start bit drops with the pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            ctrl_q  <= '0;
            flags_q <= '0;
        end else begin
            start_q <= start_fire;
            busy_q  <= start_fire | (busy_q & ~done_i);
            if (commit && is_ctrl) begin
                for (int i = 0; i < CTRL_WIDTH; i++) begin
                    if (wr_strb[i / DATA_WIDTH]) ctrl_q[i] <= pwdata_i[i] & CTRL_MASK[i];
                end
            end else if (start_q) begin
                ctrl_q[CTRL_START] <= 1'b0;
            end
            if (start_q)         flags_q <= '0;
            else if (flags_we_i) flags_q <= flags_i;
        end
    end

    matmul_operand_buf u_opa (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (commit & is_opa),
        .line_i  (line),
        .strb_i  (wr_strb),
        .wdata_i (pwdata_i),
        .rdata_o (opa_rdata),
        .lines_o (opa_o)
    );

    matmul_operand_buf u_opb (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (commit & is_opb),
        .line_i  (line),
        .strb_i  (wr_strb),
        .wdata_i (pwdata_i),
        .rdata_o (opb_rdata),
        .lines_o (opb_o)
    );

    assign busy_o  = busy_q;
    assign start_o = start_q;
    assign ctrl_o  = ctrl_q;

endmodule
